// File: rtl/pwm_hbridge_gen.sv
// pwm_hbridge_gen: bipolar H-bridge PWM with per-leg dead-time, run/arm sequencing and latched fault handling.
module pwm_hbridge_gen #(
  parameter int PERIOD   = 2500,
  parameter int DEADTIME = 50,
  parameter int RSTPULSE = 16
) (
  input  logic        CLK_50M,
  input  logic        Rst_n,
  input  logic        run_en,
  input  logic        fault_n,
  input  logic        clr_req,
  input  logic [15:0] duty_cmp,
  input  logic        duty_load,
  output logic        PWM_LH_D,
  output logic        PWM_LL_D,
  output logic        PWM_RH_D,
  output logic        PWM_RL_D,
  output logic        period_sync,
  output logic        Reset_D,
  output logic        running
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, FAULT} top_t;
  typedef enum logic [1:0] {OFF, DT, HI, LO} leg_t;
  localparam logic [15:0] P_LAST  = 16'(PERIOD - 1);
  localparam logic [15:0] P_MAX   = 16'(PERIOD);
  localparam logic [15:0] DT_LAST = 16'(DEADTIME - 1);
  localparam logic [15:0] RP      = 16'(RSTPULSE);
  top_t        top, top_nx;
  leg_t        leg [2];
  leg_t        leg_nx [2];
  logic [15:0] dtc [2];
  logic [15:0] dtc_nx [2];
  logic        dtr [2];
  logic        dtr_nx [2];
  logic [15:0] cnt, cnt_nx, shadow, cmp, rcnt, rcnt_nx;
  logic [1:0]  raw;
  logic        leg_en, clr_ok, counting;
  assign period_sync = cnt == P_LAST;
  assign raw[0]      = cnt < cmp;
  assign raw[1]      = ~raw[0];
  assign clr_ok      = top == FAULT && clr_req && fault_n;
  // legs drop out in the same cycle the top FSM leaves RUN
  assign leg_en      = top == RUN && run_en && fault_n;
  always_comb begin
    top_nx = top;
    if (!fault_n) top_nx = FAULT;
    else
      case (top)
        IDLE:    top_nx = run_en ? ARM : IDLE;
        ARM:     top_nx = !run_en ? IDLE : period_sync ? RUN : ARM;
        RUN:     top_nx = run_en ? RUN : IDLE;
        default: top_nx = clr_req ? IDLE : FAULT;
      endcase
  end
  assign counting = (top == ARM || top == RUN) && (top_nx == ARM || top_nx == RUN);
  assign cnt_nx   = !counting ? 16'd0 : period_sync ? 16'd0 : cnt + 16'd1;
  assign rcnt_nx  = !fault_n ? 16'd0 : clr_ok ? RP : rcnt != 16'd0 ? rcnt - 16'd1 : rcnt;
  // a raw change while in DT restarts the count so no side gets a pulse shorter than the dead-time
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      leg_nx[i] = leg[i];
      dtc_nx[i] = dtc[i];
      dtr_nx[i] = dtr[i];
      if (!leg_en) leg_nx[i] = OFF;
      else if (leg[i] == DT) begin
        if (raw[i] != dtr[i]) begin
          dtc_nx[i] = 16'd0;
          dtr_nx[i] = raw[i];
        end else if (dtc[i] == DT_LAST) leg_nx[i] = raw[i] ? HI : LO;
        else dtc_nx[i] = dtc[i] + 16'd1;
      end else if (leg[i] == OFF || raw[i] != (leg[i] == HI)) begin
        leg_nx[i] = DT;
        dtc_nx[i] = 16'd0;
        dtr_nx[i] = raw[i];
      end
    end
  end
  always_ff @(posedge CLK_50M or negedge Rst_n) begin
    if (!Rst_n) begin
      top      <= IDLE;
      cnt      <= '0;
      shadow   <= '0;
      cmp      <= '0;
      rcnt     <= '0;
      leg      <= '{OFF, OFF};
      dtc      <= '{16'd0, 16'd0};
      dtr      <= '{1'b0, 1'b0};
      PWM_LH_D <= 1'b0;
      PWM_LL_D <= 1'b0;
      PWM_RH_D <= 1'b0;
      PWM_RL_D <= 1'b0;
      Reset_D  <= 1'b0;
      running  <= 1'b0;
    end else begin
      top      <= top_nx;
      cnt      <= cnt_nx;
      shadow   <= duty_load ? (duty_cmp > P_MAX ? P_MAX : duty_cmp) : shadow;
      cmp      <= period_sync ? shadow : cmp;
      rcnt     <= rcnt_nx;
      leg      <= leg_nx;
      dtc      <= dtc_nx;
      dtr      <= dtr_nx;
      PWM_LH_D <= leg_nx[0] == HI;
      PWM_LL_D <= leg_nx[0] == LO;
      PWM_RH_D <= leg_nx[1] == HI;
      PWM_RL_D <= leg_nx[1] == LO;
      Reset_D  <= rcnt_nx != 16'd0;
      running  <= top_nx == RUN;
    end
  end
endmodule

// File: tb/tb_pwm_hbridge_gen.sv
// tb_pwm_hbridge_gen: directed checks of carrier, dead-time, duty reload, fault/clear, clamp and reset.
module tb_pwm_hbridge_gen;
  logic CLK_50M = 0, Rst_n = 0, run_en = 0, fault_n = 1, clr_req = 0, duty_load = 0;
  logic [15:0] duty_cmp = 0;
  logic PWM_LH_D, PWM_LL_D, PWM_RH_D, PWM_RL_D, period_sync, Reset_D, running;
  logic [3:0] gates;
  logic [1:0] gh, gl;
  logic [2499:0] s_lh, s_ll, s_rh, s_rl;
  int checks = 0, errors = 0, n;
  logic [1:0] last [2] = '{2'd0, 2'd0};
  int off_c [2] = '{0, 0};

  pwm_hbridge_gen dut (
    .CLK_50M(CLK_50M), .Rst_n(Rst_n), .run_en(run_en), .fault_n(fault_n), .clr_req(clr_req),
    .duty_cmp(duty_cmp), .duty_load(duty_load), .PWM_LH_D(PWM_LH_D), .PWM_LL_D(PWM_LL_D),
    .PWM_RH_D(PWM_RH_D), .PWM_RL_D(PWM_RL_D), .period_sync(period_sync), .Reset_D(Reset_D),
    .running(running)
  );

  assign gates = {PWM_LH_D, PWM_LL_D, PWM_RH_D, PWM_RL_D};
  assign gh = {PWM_RH_D, PWM_LH_D};
  assign gl = {PWM_RL_D, PWM_LL_D};
  always #10 CLK_50M = ~CLK_50M;

  task automatic tick;
    @(posedge CLK_50M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_sync(input string tag);
    int k = 0;
    while (period_sync !== 1'b1 && k < 3000) begin
      tick;
      k++;
    end
    chk(tag, period_sync, 1);
  endtask

  // one full carrier period sampled at cnt 0..2499, optional duty reload at cnt at_i
  task automatic capture(input int at_i, input logic [15:0] at_duty);
    for (int i = 0; i < 2500; i++) begin
      tick;
      s_lh[i] = PWM_LH_D;
      s_ll[i] = PWM_LL_D;
      s_rh[i] = PWM_RH_D;
      s_rl[i] = PWM_RL_D;
      duty_load = (i == at_i);
      if (i == at_i) duty_cmp = at_duty;
    end
  endtask

  // continuous shoot-through and dead-time watch on both legs
  always @(negedge CLK_50M) begin
    for (int k = 0; k < 2; k++) begin
      checks++;
      assert (!(gh[k] === 1'b1 && gl[k] === 1'b1)) else begin
        errors++;
        $error("FAIL overlap leg%0d: high=%b low=%b expected not both 1", k, gh[k], gl[k]);
      end
      if (!Rst_n) begin
        last[k] = 2'd0;
        off_c[k] = 0;
      end else if (gh[k] === 1'b1 || gl[k] === 1'b1) begin
        if (last[k] != 2'd0 && last[k] != (gh[k] ? 2'd1 : 2'd2)) begin
          checks++;
          assert (off_c[k] >= 50) else begin
            errors++;
            $error("FAIL deadtime leg%0d: observed %0d off cycles expected >=50", k, off_c[k]);
          end
        end
        last[k] = gh[k] ? 2'd1 : 2'd2;
        off_c[k] = 0;
      end else off_c[k]++;
    end
  end

  initial begin
    repeat (3) tick;
    chk("rst_gates", gates, 0);
    chk("rst_misc", {period_sync, Reset_D, running}, 0);
    Rst_n = 1;
    repeat (5) tick;
    chk("idle_running", running, 0);
    chk("idle_gates", gates, 0);
    duty_cmp = 1250;
    duty_load = 1;
    tick;
    duty_load = 0;
    run_en = 1;
    tick;
    chk("arm_running", running, 0);
    wait_sync("arm_sync");
    chk("arm_gates", gates, 0);
    capture(-1, 0);
    chk("run_running", running, 1);
    chk("p1_lh_cnt0", s_lh[0], 0);
    chk("p1_lh_cnt50", s_lh[50], 0);
    chk("p1_lh_cnt51", s_lh[51], 1);
    chk("p1_rl_cnt51", s_rl[51], 1);
    chk("p1_lh_count", $countones(s_lh), 1200);
    capture(-1, 0);
    chk("p2_lh_count", $countones(s_lh), 1200);
    chk("p2_ll_count", $countones(s_ll), 1200);
    chk("p2_rh_count", $countones(s_rh), 1200);
    chk("p2_rl_count", $countones(s_rl), 1200);
    chk("p2_l_off", $countones(~(s_lh | s_ll)), 100);
    chk("p2_ll_cnt0", s_ll[0], 1);
    chk("p2_lh_cnt1250", s_lh[1250], 1);
    chk("p2_lh_cnt1251", s_lh[1251], 0);
    chk("p2_ll_cnt1300", s_ll[1300], 0);
    chk("p2_ll_cnt1301", s_ll[1301], 1);
    chk("p2_rh_cnt0", s_rh[0], 1);
    chk("p2_rl_cnt51", s_rl[51], 1);
    capture(100, 500);
    chk("p3_lh_cnt600", s_lh[600], 1);
    chk("p3_lh_cnt1251", s_lh[1251], 0);
    chk("p3_lh_count", $countones(s_lh), 1200);
    capture(-1, 0);
    chk("p4_lh_cnt500", s_lh[500], 1);
    chk("p4_lh_cnt501", s_lh[501], 0);
    chk("p4_ll_cnt550", s_ll[550], 0);
    chk("p4_ll_cnt551", s_ll[551], 1);
    chk("p4_lh_count", $countones(s_lh), 450);
    repeat (200) tick;
    chk("pre_fault_lh", PWM_LH_D, 1);
    fault_n = 0;
    tick;
    chk("fault_gates", gates, 0);
    chk("fault_running", running, 0);
    clr_req = 1;
    tick;
    clr_req = 0;
    tick;
    chk("clr_ignored_rstd", Reset_D, 0);
    chk("clr_ignored_gates", gates, 0);
    run_en = 0;
    fault_n = 1;
    repeat (3) tick;
    chk("fault_held_rstd", Reset_D, 0);
    clr_req = 1;
    tick;
    clr_req = 0;
    chk("rstd_start", Reset_D, 1);
    n = 1;
    repeat (20) begin
      tick;
      n += int'(Reset_D);
    end
    chk("rstd_width", n, 16);
    chk("post_clr_running", running, 0);
    fault_n = 0;
    tick;
    fault_n = 1;
    clr_req = 1;
    tick;
    clr_req = 0;
    repeat (4) tick;
    chk("rstd_mid", Reset_D, 1);
    fault_n = 0;
    tick;
    chk("rstd_abort", Reset_D, 0);
    fault_n = 1;
    repeat (20) tick;
    chk("rstd_stays_low", Reset_D, 0);
    clr_req = 1;
    tick;
    clr_req = 0;
    repeat (20) tick;
    duty_cmp = 3000;
    duty_load = 1;
    tick;
    duty_load = 0;
    run_en = 1;
    tick;
    wait_sync("clamp_sync");
    capture(-1, 0);
    chk("clamp_p1_lh51", s_lh[51], 1);
    capture(-1, 0);
    chk("clamp_lh_count", $countones(s_lh), 2500);
    chk("clamp_ll_count", $countones(s_ll), 0);
    chk("clamp_rl_count", $countones(s_rl), 2500);
    repeat (100) tick;
    chk("pre_rst_lh", PWM_LH_D, 1);
    #5 Rst_n = 0;
    #1;
    chk("async_rst_gates", gates, 0);
    chk("async_rst_misc", {period_sync, Reset_D, running}, 0);
    tick;
    Rst_n = 1;
    repeat (10) tick;
    chk("rst_rearm_running", running, 0);
    chk("rst_rearm_gates", gates, 0);
    wait_sync("rst_resync");
    tick;
    chk("rst_run_running", running, 1);
    repeat (60) tick;
    chk("rst_cmp0_ll", PWM_LL_D, 1);
    chk("rst_cmp0_lh", PWM_LH_D, 0);
    for (int i = 0; i < 20000; i++) begin
      tick;
      run_en = (i % 4000) < 3000;
      fault_n = $urandom_range(0, 1999) != 0;
      clr_req = $urandom_range(0, 99) == 0;
      duty_load = $urandom_range(0, 299) == 0;
      duty_cmp = 16'($urandom_range(0, 3000));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_hbridge_gen.md
PWM_HBRIDGE_GEN -- requirements
Module: pwm_hbridge_gen

Interface
REQ-001 SHALL have parameter PERIOD, default 2500, carrier length in clocks (20 kHz at 50 MHz).
REQ-002 SHALL have parameter DEADTIME, default 50, dead-time in clocks (1 us).
REQ-003 SHALL have parameter RSTPULSE, default 16, Reset_D pulse width in clocks.
REQ-004 CLK_50M  input  1  sole clock, all logic on rising edge.
REQ-005 Rst_n  input  1  asynchronous, active-low reset.
REQ-006 run_en  input  1  1 = bridge may switch, 0 = graceful stop.
REQ-007 fault_n  input  1  active-low fault (OCP/OVP summary), synchronous to CLK_50M.
REQ-008 clr_req  input  1  one-cycle request to clear latched fault.
REQ-009 duty_cmp  input  16  left-leg high-side on-time in clocks per period.
REQ-010 duty_load  input  1  one-cycle strobe capturing duty_cmp into shadow register.
REQ-011 PWM_LH_D, PWM_LL_D  output  1 each  left leg high/low gate drive.
REQ-012 PWM_RH_D, PWM_RL_D  output  1 each  right leg high/low gate drive.
REQ-013 period_sync  output  1  one-cycle pulse when carrier counter wraps.
REQ-014 Reset_D  output  1  fault-clear pulse toward the protection gate.
REQ-015 running  output  1  1 while top FSM is in RUN.

Function
REQ-016 SHALL run a 16-bit carrier counter cnt 0..PERIOD-1, wrapping to 0; period_sync=1 in the cycle cnt==PERIOD-1; cnt held at 0 in IDLE and FAULT.
REQ-017 SHALL load shadow<=duty_cmp on duty_load; active compare cmp<=shadow only in the period_sync cycle (no mid-period duty change).
REQ-018 SHALL clamp duty_cmp>PERIOD to PERIOD when captured into shadow.
REQ-019 SHALL define raw_L = (cnt < cmp), raw_R = ~raw_L (bipolar switching).
REQ-020 SHALL implement per-leg FSM {OFF, DT, HI, LO}: OFF->DT when leg enabled; HI/LO->DT in the cycle raw differs from the conducting side; DT counts DEADTIME clocks then enters HI if raw=1 else LO.
REQ-021 SHALL drive high output =1 only in HI, low output =1 only in LO; both 0 in OFF and DT; outputs registered.
REQ-022 SHALL never assert PWM_xH_D and PWM_xL_D of the same leg in the same cycle, including across fault and reset.
REQ-023 SHALL give dead-time of exactly DEADTIME cycles of both-off between any high/low handover.
REQ-024 If raw toggles back during DT, SHALL restart the DT count (no short pulse shorter than dead-time on a side).
REQ-025 SHALL implement top FSM {IDLE, ARM, RUN, FAULT}: IDLE->ARM on run_en=1 and fault_n=1; ARM->RUN on next period_sync; RUN->IDLE on run_en=0; any state->FAULT on fault_n=0.
REQ-026 Legs SHALL be enabled only in RUN; leaving RUN forces both legs to OFF in the next cycle (no dead-time wait for turn-off).
REQ-027 FAULT SHALL set all four gate outputs to 0 in the cycle after fault_n=0 is sampled.
REQ-028 FAULT SHALL exit to IDLE only on clr_req=1 while fault_n=1; clr_req with fault_n=0 is ignored.
REQ-029 On fault exit SHALL assert Reset_D for exactly RSTPULSE cycles starting the cycle after the accepted clr_req; a new fault during the pulse aborts it (Reset_D=0).
REQ-030 Fault and clr_req in the same cycle: fault wins.

Reset
REQ-031 On Rst_n=0 all outputs SHALL be 0 asynchronously; cnt=0, shadow=cmp=0, top FSM=IDLE, legs=OFF, Reset_D=0.
REQ-032 After Rst_n release, first switching SHALL occur only via IDLE->ARM->RUN.

Verification
REQ-033 duty_cmp=1250 loaded, run_en=1 -> after first period_sync, LH_D high 1200 clocks, both-off 50, LL_D high 1200, both-off 50, repeating; right leg complementary.
REQ-034 duty_load of 500 mid-period -> current period unchanged, new duty from cnt=0 of next period.
REQ-035 fault_n=0 during LH_D=1 -> all gates 0 next cycle; clr_req while fault_n=0 ignored; clr_req with fault_n=1 -> Reset_D high 16 cycles, FSM IDLE.
REQ-036 duty_cmp=3000 -> clamped to 2500, left high side continuously on after initial dead-time, no LL_D pulses.
REQ-037 Rst_n pulsed low mid-period with outputs active -> all outputs 0 immediately, restart requires fresh period_sync.
REQ-038 Random duty/fault/run_en stimulus -> assertion: no same-leg high/low overlap, every handover has >=50 both-off cycles.
